// File: rtl/connect_count_feeder_pkg.sv
// rtl/connect_count_feeder_pkg.sv - shared widths and types for the connected-component feeder
package connect_count_feeder_pkg;

   localparam int GRAPH_WIDTH = 128;
   localparam int COUNT_WIDTH = 6;

   typedef logic [GRAPH_WIDTH-1:0] graph_t;
   typedef logic [COUNT_WIDTH-1:0] count_t;

endpackage

// File: rtl/connect_count_feeder_fifo.sv
// rtl/connect_count_feeder_fifo.sv - synchronous FIFO with registered full/empty and occupancy
module feeder_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i_push,
   input  logic [WIDTH-1:0]           i_data,
   input  logic                       i_pop,
   output logic [WIDTH-1:0]           o_data,
   output logic                       o_full,
   output logic                       o_empty,
   output logic [$clog2(DEPTH+1)-1:0] o_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             r_full;
   logic             r_empty;
   logic [CW-1:0]    w_count_nxt;
   logic             w_do_push;
   logic             w_do_pop;

   // Overflow/underflow requests are dropped rather than corrupting pointers.
   assign w_do_pop  = i_pop & !r_empty;
   assign w_do_push = i_push & !r_full;

   always_comb begin
      w_count_nxt = r_count;
      if (w_do_push && !w_do_pop) begin
         w_count_nxt = r_count + CW'(1);
      end else if (!w_do_push && w_do_pop) begin
         w_count_nxt = r_count - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_full   <= 1'b0;
         r_empty  <= 1'b1;
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         r_count <= w_count_nxt;
         r_full  <= (w_count_nxt == DEPTH_C);
         r_empty <= (w_count_nxt == '0);
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   assign o_data  = r_mem[r_rd_ptr];
   assign o_full  = r_full;
   assign o_empty = r_empty;
   assign o_count = r_count;

endmodule

// File: rtl/connect_count_feeder.sv
// rtl/connect_count_feeder.sv - feeds jobs to the connected-component core and buffers its results
module connect_count_feeder
   import connect_count_feeder_pkg::*;
#(
   parameter int EXTRA_DATA_WIDTH  = 10,
   parameter int DATA_IN_LATENCY   = 4,
   parameter int JOB_FIFO_DEPTH    = 4,
   parameter int RESULT_FIFO_DEPTH = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        jobValid,
   output logic                        jobReady,
   input  logic [GRAPH_WIDTH-1:0]      jobGraph,
   input  logic [EXTRA_DATA_WIDTH-1:0] jobExtraData,
   input  logic                        coreRequest,
   output logic                        coreStart,
   output logic [GRAPH_WIDTH-1:0]      coreGraph,
   output logic [COUNT_WIDTH-1:0]      coreCountInit,
   output logic [EXTRA_DATA_WIDTH-1:0] coreExtraData,
   input  logic                        coreDone,
   input  logic [COUNT_WIDTH-1:0]      coreCount,
   input  logic [EXTRA_DATA_WIDTH-1:0] coreTag,
   output logic                        resultValid,
   input  logic                        resultReady,
   output logic [COUNT_WIDTH-1:0]      resultCount,
   output logic [EXTRA_DATA_WIDTH-1:0] resultExtraData
);

   localparam int JOB_W  = GRAPH_WIDTH + EXTRA_DATA_WIDTH;
   localparam int RES_W  = COUNT_WIDTH + EXTRA_DATA_WIDTH;
   localparam int PIPE_W = 1 + JOB_W;
   localparam int JCW    = $clog2(JOB_FIFO_DEPTH + 1);
   localparam int RCW    = $clog2(RESULT_FIFO_DEPTH + 1);
   localparam int RCW1   = RCW + 1;
   localparam logic [JCW-1:0] JOB_DEPTH_C = JCW'(JOB_FIFO_DEPTH);
   localparam logic [RCW:0]   RES_DEPTH_C = RCW1'(RESULT_FIFO_DEPTH);

   logic              w_job_push;
   logic              w_job_full;
   logic              w_job_empty;
   logic [JOB_W-1:0]  w_job_data;
   logic [JCW-1:0]    w_job_count;
   logic              w_issue;
   logic              w_credit_ok;
   logic              w_res_full;
   logic              w_res_empty;
   logic              w_res_pop;
   logic [RES_W-1:0]  w_res_data;
   logic [RCW-1:0]    w_res_count;
   logic [PIPE_W-1:0] r_pipe [DATA_IN_LATENCY];
   logic [RCW-1:0]    r_in_flight;

   assign jobReady   = !rst & !w_job_full;
   assign w_job_push = jobValid & jobReady;

   feeder_fifo #(
      .WIDTH (JOB_W),
      .DEPTH (JOB_FIFO_DEPTH)
   ) u_job_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_job_push),
      .i_data  ({jobGraph, jobExtraData}),
      .i_pop   (w_issue),
      .o_data  (w_job_data),
      .o_full  (w_job_full),
      .o_empty (w_job_empty),
      .o_count (w_job_count)
   );

   // Every issued job reserves a result slot until its result leaves the buffer.
   assign w_credit_ok = ({1'b0, r_in_flight} + {1'b0, w_res_count}) < RES_DEPTH_C;
   assign w_issue     = coreRequest & !w_job_empty & w_credit_ok & !rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DATA_IN_LATENCY; i++) begin
            r_pipe[i] <= '0;
         end
      end else begin
         r_pipe[0] <= w_issue ? {1'b1, w_job_data} : '0;
         for (int i = 1; i < DATA_IN_LATENCY; i++) begin
            r_pipe[i] <= r_pipe[i-1];
         end
      end
   end

   assign {coreStart, coreGraph, coreExtraData} = r_pipe[DATA_IN_LATENCY-1];
   assign coreCountInit = '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_in_flight <= '0;
      end else begin
         case ({w_issue, coreDone})
            2'b10:   r_in_flight <= r_in_flight + RCW'(1);
            2'b01:   r_in_flight <= r_in_flight - RCW'(1);
            default: r_in_flight <= r_in_flight;
         endcase
      end
   end

   assign resultValid = !w_res_empty;
   assign w_res_pop   = resultValid & resultReady;

   feeder_fifo #(
      .WIDTH (RES_W),
      .DEPTH (RESULT_FIFO_DEPTH)
   ) u_res_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (coreDone),
      .i_data  ({coreCount, coreTag}),
      .i_pop   (w_res_pop),
      .o_data  (w_res_data),
      .o_full  (w_res_full),
      .o_empty (w_res_empty),
      .o_count (w_res_count)
   );

   assign resultCount     = w_res_data[EXTRA_DATA_WIDTH +: COUNT_WIDTH];
   assign resultExtraData = w_res_data[EXTRA_DATA_WIDTH-1:0];

   // A result with no reserved slot means the core and feeder disagree about outstanding work.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (coreDone) begin
            assert (!w_res_full) else $fatal(1, "coreDone with result buffer full");
            assert (r_in_flight != '0) else $fatal(1, "coreDone with no job in flight");
         end
         assert (w_job_count <= JOB_DEPTH_C) else $fatal(1, "job buffer occupancy out of range");
      end
   end

endmodule

// File: tb/tb_connect_count_feeder.sv
// tb/tb_connect_count_feeder.sv - randomized scoreboard bench with a stand-in core
module tb_connect_count_feeder;

   localparam int EDW      = 10;
   localparam int LAT      = 4;
   localparam int CORE_LAT = 6;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst;
   logic             jobValid;
   logic             jobReady;
   logic [127:0]     jobGraph;
   logic [EDW-1:0]   jobExtraData;
   logic             coreRequest;
   logic             coreStart;
   logic [127:0]     coreGraph;
   logic [5:0]       coreCountInit;
   logic [EDW-1:0]   coreExtraData;
   logic             coreDone;
   logic [5:0]       coreCount;
   logic [EDW-1:0]   coreTag;
   logic             resultValid;
   logic             resultReady;
   logic [5:0]       resultCount;
   logic [EDW-1:0]   resultExtraData;

   connect_count_feeder dut (
      .clk             (clk),
      .rst             (rst),
      .jobValid        (jobValid),
      .jobReady        (jobReady),
      .jobGraph        (jobGraph),
      .jobExtraData    (jobExtraData),
      .coreRequest     (coreRequest),
      .coreStart       (coreStart),
      .coreGraph       (coreGraph),
      .coreCountInit   (coreCountInit),
      .coreExtraData   (coreExtraData),
      .coreDone        (coreDone),
      .coreCount       (coreCount),
      .coreTag         (coreTag),
      .resultValid     (resultValid),
      .resultReady     (resultReady),
      .resultCount     (resultCount),
      .resultExtraData (resultExtraData)
   );

   typedef struct {
      logic [127:0]   g;
      logic [EDW-1:0] t;
   } job_t;
   typedef struct {
      logic [5:0]     c;
      logic [EDW-1:0] t;
   } res_t;
   typedef struct packed {
      logic           start;
      logic [5:0]     c;
      logic [EDW-1:0] t;
   } cslot_t;

   job_t   iss_q[$];
   res_t   exp_q[$];
   cslot_t cpipe [CORE_LAT];
   cslot_t couts;
   logic [LAT-1:0] req_hist;
   logic   slot;
   int     checks = 0;
   int     errors = 0;
   int     n_start = 0;
   int     n_res = 0;
   logic [5:0]     last_count;
   logic [EDW-1:0] last_tag;

   // Stand-in core answer: number of runs of consecutive set bits, truncated to 6 bits.
   function automatic logic [5:0] runs(input logic [127:0] g);
      int   n = 0;
      logic prev = 1'b0;
      for (int i = 0; i < 128; i++) begin
         if (g[i] && !prev) n++;
         prev = g[i];
      end
      return 6'(n);
   endfunction

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, req);
      end
   endtask

   // Job acceptance: expected issue order and expected results.
   always @(negedge clk) begin
      if (rst) begin
         iss_q.delete();
         exp_q.delete();
      end else if (jobValid && jobReady) begin
         iss_q.push_back('{jobGraph, jobExtraData});
         exp_q.push_back('{runs(jobGraph), jobExtraData});
      end
   end

   // Result monitor.
   always @(negedge clk) begin
      if (!rst && resultValid && resultReady) begin
         res_t e;
         n_res++;
         last_count = resultCount;
         last_tag   = resultExtraData;
         if (exp_q.size() == 0) begin
            chk("unexpected_result", 1, 0);
         end else begin
            e = exp_q.pop_front();
            chk("result_count", resultCount, e.c);
            chk("result_tag", resultExtraData, e.t);
         end
      end
   end

   // Stand-in core: consumes start/graph LAT cycles after each request, answers CORE_LAT later.
   initial begin
      req_hist = '0;
      couts    = '0;
      for (int i = 0; i < CORE_LAT; i++) cpipe[i] = '0;
      coreDone = 1'b0;
      coreCount = '0;
      coreTag = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            req_hist = '0;
            couts    = '0;
            for (int i = 0; i < CORE_LAT; i++) cpipe[i] = '0;
         end else begin
            slot     = req_hist[LAT-1];
            req_hist = {req_hist[LAT-2:0], coreRequest};
            couts    = cpipe[CORE_LAT-1];
            for (int i = CORE_LAT - 1; i > 0; i--) cpipe[i] = cpipe[i-1];
            cpipe[0] = '0;
            if (slot && coreStart) begin
               job_t j;
               n_start++;
               if (iss_q.size() == 0) begin
                  chk("start_without_job", 1, 0);
               end else begin
                  j = iss_q.pop_front();
                  chk("core_graph", coreGraph, j.g);
                  chk("core_tag", coreExtraData, j.t);
               end
               cpipe[0] = '{1'b1, runs(coreGraph), coreExtraData};
            end else if (!slot && coreStart) begin
               chk("start_off_request_slot", 1, 0);
            end
         end
         @(posedge clk);
         #1;
         coreDone  = couts.start;
         coreCount = couts.c;
         coreTag   = couts.t;
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push_job(input logic [127:0] g, input logic [EDW-1:0] t);
      int n = 0;
      @(posedge clk);
      #1;
      jobValid = 1'b1;
      jobGraph = g;
      jobExtraData = t;
      forever begin
         @(negedge clk);
         if (jobReady) break;
         n++;
         if (n > 300) begin
            chk("push_timeout", 0, 1);
            break;
         end
      end
      @(posedge clk);
      #1;
      jobValid = 1'b0;
   endtask

   initial begin
      int base;
      int rb;
      rst = 1'b1;
      jobValid = 1'b0;
      jobGraph = '0;
      jobExtraData = '0;
      coreRequest = 1'b1;
      resultReady = 1'b0;

      repeat (20) begin
         @(negedge clk);
         chk("reset_coreStart", coreStart, 0);
         chk("reset_jobReady", jobReady, 0);
         chk("reset_resultValid", resultValid, 0);
      end
      chk("reset_coreGraph", coreGraph, 0);
      chk("reset_coreExtraData", coreExtraData, 0);
      chk("coreCountInit", coreCountInit, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      coreRequest = 1'b0;
      resultReady = 1'b1;
      @(negedge clk);
      chk("jobReady_after_reset", jobReady, 1);

      // Single job.
      base = n_start;
      rb = n_res;
      push_job(128'h1, 10'd5);
      coreRequest = 1'b1;
      cyc(1);
      coreRequest = 1'b0;
      cyc(20);
      chk("t2_starts", n_start - base, 1);
      chk("t2_results", n_res - rb, 1);
      chk("t2_count", last_count, 1);
      chk("t2_tag", last_tag, 5);

      // Back-to-back jobs.
      base = n_start;
      rb = n_res;
      push_job(128'h3, 10'd1);
      push_job(128'h81, 10'd2);
      coreRequest = 1'b1;
      cyc(2);
      coreRequest = 1'b0;
      cyc(20);
      chk("t3_starts", n_start - base, 2);
      chk("t3_results", n_res - rb, 2);
      chk("t3_last_count", last_count, 2);
      chk("t3_last_tag", last_tag, 2);

      // Credit limit with results held back.
      base = n_start;
      rb = n_res;
      resultReady = 1'b0;
      coreRequest = 1'b1;
      for (int i = 0; i < 20; i++) begin
         push_job({$urandom, $urandom, $urandom, $urandom}, 10'(100 + i));
      end
      cyc(30);
      chk("t4_issued", n_start - base, 16);
      @(negedge clk);
      chk("t4_jobReady_full", jobReady, 0);
      chk("t4_resultValid", resultValid, 1);
      for (int p = 0; p < 4; p++) begin
         @(posedge clk);
         #1;
         resultReady = 1'b1;
         cyc(1);
         resultReady = 1'b0;
         cyc(20);
         chk("t4_pulse_issue", n_start - base, 17 + p);
      end
      resultReady = 1'b1;
      cyc(40);
      coreRequest = 1'b0;
      chk("t4_all_issued", n_start - base, 20);
      chk("t4_all_results", n_res - rb, 20);

      // Requests with nothing queued only produce bubbles.
      base = n_start;
      rb = n_res;
      coreRequest = 1'b1;
      cyc(12);
      coreRequest = 1'b0;
      cyc(20);
      chk("t5_no_starts", n_start - base, 0);
      chk("t5_no_results", n_res - rb, 0);
      @(negedge clk);
      chk("t5_resultValid", resultValid, 0);

      // Randomized traffic.
      repeat (800) begin
         @(posedge clk);
         #1;
         coreRequest  = 1'($urandom_range(0, 1));
         resultReady  = ($urandom_range(0, 3) != 0);
         jobValid     = 1'($urandom_range(0, 1));
         jobGraph     = {$urandom, $urandom, $urandom, $urandom} & {$urandom, $urandom, $urandom, $urandom};
         jobExtraData = 10'($urandom);
      end
      @(posedge clk);
      #1;
      jobValid = 1'b0;
      coreRequest = 1'b1;
      resultReady = 1'b1;
      cyc(80);
      coreRequest = 1'b0;
      chk("rand_results_drained", exp_q.size(), 0);
      chk("rand_issues_drained", iss_q.size(), 0);

      // Reset with work in flight.
      resultReady = 1'b0;
      push_job(128'hF0F, 10'd21);
      push_job(128'h5, 10'd22);
      push_job(128'h7, 10'd23);
      coreRequest = 1'b1;
      cyc(3);
      rst = 1'b1;
      coreRequest = 1'b0;
      cyc(24);
      @(negedge clk);
      chk("t6_reset_resultValid", resultValid, 0);
      chk("t6_reset_coreStart", coreStart, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("t6_jobReady", jobReady, 1);
      chk("t6_resultValid", resultValid, 0);
      base = n_start;
      rb = n_res;
      resultReady = 1'b1;
      push_job(128'h81, 10'd9);
      coreRequest = 1'b1;
      cyc(1);
      coreRequest = 1'b0;
      cyc(20);
      chk("t6_starts", n_start - base, 1);
      chk("t6_results", n_res - rb, 1);
      chk("t6_count", last_count, 2);
      chk("t6_tag", last_tag, 9);
      chk("t6_queue_empty", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
